rgb_sequencer: RTL and testbench
================================

RGB_SEQUENCER -- requirements
Module: rgb_sequencer

Interface
REQ-001 The module SHALL have exactly one clock and one reset; reset is synchronous and active-high. Ports and parameters are listed below.
REQ-002 Parameter PERIOD_TICKS, default 12_000_000: clk cycles between auto-advances (1 s at 12 MHz); legal range >= 2.
REQ-003 Port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port step, input, 1 bit: single-cycle advance pulse, already debounced and edge-detected upstream.
REQ-006 Port auto_en, input, 1 bit: level signal; high selects timed auto-advance.
REQ-007 Port reverse, input, 1 bit: level signal; high means the sequence runs backward.
REQ-008 Port brightness, input, 2 bits: duty level; on for (brightness+1) of every 4 cycles.
REQ-009 Port rgb, output, 3 bits: registered LED drive {r,g,b}, PWM-gated.
REQ-010 Port color_index, output, 3 bits: registered current sequence position, 0..6.

Function
REQ-011 The FSM SHALL have exactly three states: S_OFF, S_MANUAL and S_AUTO.
REQ-012 The color table SHALL be, by index 0..6: 100 red, 110 yellow, 010 green, 011 cyan, 001 blue, 101 magenta, 111 white; black (000) is never a table entry.
REQ-013 From S_OFF, the FSM SHALL go to S_AUTO when auto_en is high, else to S_MANUAL when step is high; the index stays 0 on this exit, and step does not advance it.
REQ-014 From S_MANUAL, the FSM SHALL go to S_AUTO on auto_en high; a step in that same cycle still advances the index once.
REQ-015 From S_AUTO, the FSM SHALL go to S_MANUAL on auto_en low and clear the tick counter.
REQ-016 Advance rule: forward is 6->0 wrap; reverse is 0->6 wrap. Direction is sampled in the advancing cycle.
REQ-017 A step in S_MANUAL or S_AUTO SHALL update color_index on the clock edge where step is sampled high (latency 1).
REQ-018 The tick counter SHALL run only in S_AUTO, counting 0..PERIOD_TICKS-1; at terminal count it advances the index and returns to 0.
REQ-019 A step in S_AUTO SHALL advance once and clear the tick counter; if step coincides with terminal count, the block advances exactly once.
REQ-020 In S_OFF, rgb SHALL be 000 regardless of other inputs.
REQ-021 A free-running 2-bit pwm counter SHALL drive rgb = table[color_index] when pwm_cnt <= brightness, else 000.
REQ-022 rgb SHALL be registered and lag color_index/pwm_cnt by one cycle; brightness=3 gives a constant color.
REQ-023 step held high for N cycles SHALL produce N advances; pulse-shaping is upstream's responsibility.
REQ-024 Arithmetic widths: the tick counter is $clog2(PERIOD_TICKS) bits with no overflow; the index never takes the value 7.

Reset
REQ-025 While rst is high: state=S_OFF, color_index=0, rgb=000, tick counter=0, pwm_cnt=0, regardless of other inputs.
REQ-026 Reset asserted mid-operation SHALL take effect on the next edge with no partial advance; after rst deasserts, the block waits in S_OFF.

Structure
REQ-027 A shared package rgb_sequencer_pkg SHALL hold the state enum, the NUM_COLORS=7 constant and the seven color constants, defined as a function or localparam table.
REQ-028 One sub-module, tick_timer, SHALL implement the tick counter with a PERIOD parameter, enable and clear inputs, and a terminal-count output.
REQ-029 All outputs SHALL come straight from flops; there are no combinational paths from inputs to outputs.

Verification
REQ-030 Reset, then 7 step pulses with auto_en=0, reverse=0, brightness=3: the first step only leaves S_OFF; color_index then follows 1,2,3,4,5,6, and the rgb sequence is 100,110,010,011,001,101,111.
REQ-031 In S_MANUAL at index 0 with reverse=1, one step: color_index=6, and rgb=111 one cycle later.
REQ-032 PERIOD_TICKS=4, auto_en=1 from reset: the index advances every 4 cycles, wrapping 6->0; a step on the terminal-count cycle yields a single advance.
REQ-033 brightness=0 at index 0: rgb=100 on exactly 1 of every 4 cycles; with brightness=2, rgb=100 on 3 of every 4 cycles.
REQ-034 rst pulsed while in S_AUTO at index 4: on the next edge color_index=0 and rgb=000, and the block stays in S_OFF until step or auto_en.

Source files
------------

// File: rtl/rgb_sequencer_pkg.sv
// Shared types and color table for the RGB LED sequencer.
package rgb_sequencer_pkg;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_MANUAL = 2'd1,
        S_AUTO   = 2'd2
    } state_e;

    localparam int NUM_COLORS = 7;
    localparam logic [2:0] IDX_LAST = 3'(NUM_COLORS - 1);

    localparam logic [2:0] C_RED     = 3'b100;
    localparam logic [2:0] C_YELLOW  = 3'b110;
    localparam logic [2:0] C_GREEN   = 3'b010;
    localparam logic [2:0] C_CYAN    = 3'b011;
    localparam logic [2:0] C_BLUE    = 3'b001;
    localparam logic [2:0] C_MAGENTA = 3'b101;
    localparam logic [2:0] C_WHITE   = 3'b111;

    function automatic logic [2:0] color_of(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = C_RED;
            3'd1:    c = C_YELLOW;
            3'd2:    c = C_GREEN;
            3'd3:    c = C_CYAN;
            3'd4:    c = C_BLUE;
            3'd5:    c = C_MAGENTA;
            3'd6:    c = C_WHITE;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] next_index(input logic [2:0] idx,
                                              input logic rev);
        logic [2:0] n;
        if (rev) begin
            n = (idx == 3'd0) ? IDX_LAST : idx - 3'd1;
        end else begin
            n = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/rgb_sequencer_tick_timer.sv
// Period counter for timed auto-advance; tc marks the last tick of a period.
module tick_timer #(
    parameter int PERIOD = 12_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tc = en && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rgb_sequencer.sv
// Seven-color LED sequencer with manual/auto advance and 4-level PWM dimming.
module rgb_sequencer
    import rgb_sequencer_pkg::*;
#(
    parameter int PERIOD_TICKS = 12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       auto_en,
    input  logic       reverse,
    input  logic [1:0] brightness,
    output logic [2:0] rgb,
    output logic [2:0] color_index
);

    state_e     state_q, state_d;
    logic [2:0] color_index_q, color_index_d;
    logic [2:0] rgb_q, rgb_d;
    logic [1:0] pwm_cnt_q, pwm_cnt_d;
    logic       advance;
    logic       tick_en;
    logic       tick_clr;
    logic       tick_tc;

    // Counter runs only while auto mode is held; any step or exit restarts it.
    assign tick_en  = (state_q == S_AUTO) && auto_en;
    assign tick_clr = (state_q != S_AUTO) || !auto_en || step;

    tick_timer #(
        .PERIOD(PERIOD_TICKS)
    ) u_tick_timer (
        .clk(clk),
        .rst(rst),
        .en (tick_en),
        .clr(tick_clr),
        .tc (tick_tc)
    );

    always_comb begin
        state_d       = state_q;
        color_index_d = color_index_q;
        advance       = 1'b0;
        case (state_q)
            S_OFF: begin
                if (auto_en) begin
                    state_d = S_AUTO;
                end else if (step) begin
                    state_d = S_MANUAL;
                end
            end
            S_MANUAL: begin
                advance = step;
                if (auto_en) begin
                    state_d = S_AUTO;
                end
            end
            S_AUTO: begin
                advance = step || tick_tc;
                if (!auto_en) begin
                    state_d = S_MANUAL;
                end
            end
            default: state_d = S_OFF;
        endcase
        if (advance) begin
            color_index_d = next_index(color_index_q, reverse);
        end
        pwm_cnt_d = pwm_cnt_q + 2'd1;
        rgb_d     = 3'b000;
        if (state_q != S_OFF && pwm_cnt_q <= brightness) begin
            rgb_d = color_of(color_index_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_OFF;
            color_index_q <= 3'd0;
            rgb_q         <= 3'b000;
            pwm_cnt_q     <= 2'd0;
        end else begin
            state_q       <= state_d;
            color_index_q <= color_index_d;
            rgb_q         <= rgb_d;
            pwm_cnt_q     <= pwm_cnt_d;
        end
    end

    assign rgb         = rgb_q;
    assign color_index = color_index_q;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Scoreboard bench for rgb_sequencer with a short auto period.
module tb_rgb_sequencer;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step = 1'b0;
    logic       auto_en = 1'b0;
    logic       reverse = 1'b0;
    logic [1:0] brightness = 2'd3;
    logic [2:0] rgb;
    logic [2:0] color_index;

    rgb_sequencer #(
        .PERIOD_TICKS(P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .auto_en    (auto_en),
        .reverse    (reverse),
        .brightness (brightness),
        .rgb        (rgb),
        .color_index(color_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] idx;
        logic [2:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;

    logic [2:0] tbl [7] = '{3'b100, 3'b110, 3'b010, 3'b011,
                            3'b001, 3'b101, 3'b111};

    // Reference model: 0=off, 1=manual, 2=auto
    int m_state = 0;
    int m_idx = 0;
    int m_tick = 0;
    int m_pwm = 0;
    logic [2:0] m_rgb = 3'b000;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(input logic s, a, r, input logic [1:0] b,
                         input logic rs);
        logic [2:0] nr;
        bit adv;
        adv = 0;
        if (rs) begin
            m_state = 0; m_idx = 0; m_tick = 0; m_pwm = 0; m_rgb = 3'b000;
            return;
        end
        nr = (m_state != 0 && m_pwm <= int'(b)) ? tbl[m_idx] : 3'b000;
        if (m_state == 0) begin
            if (a) m_state = 2;
            else if (s) m_state = 1;
            m_tick = 0;
        end else if (m_state == 1) begin
            adv = s;
            if (a) m_state = 2;
            m_tick = 0;
        end else begin
            if (!a) begin
                m_state = 1; m_tick = 0; adv = s;
            end else if (s) begin
                adv = 1; m_tick = 0;
            end else if (m_tick == P - 1) begin
                adv = 1; m_tick = 0;
            end else begin
                m_tick++;
            end
        end
        if (adv) begin
            if (r) m_idx = (m_idx == 0) ? 6 : m_idx - 1;
            else m_idx = (m_idx == 6) ? 0 : m_idx + 1;
        end
        m_pwm = (m_pwm + 1) % 4;
        m_rgb = nr;
    endtask

    task automatic cyc(input logic s, a, r, input logic [1:0] b,
                       input logic rs = 1'b0);
        exp_t e;
        step = s; auto_en = a; reverse = r; brightness = b; rst = rs;
        model(s, a, r, b, rs);
        e.idx = 3'(m_idx);
        e.rgb = m_rgb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("idx", int'(color_index), int'(e.idx));
            check("rgb", int'(rgb), int'(e.rgb));
        end
    endtask

    int cnt;
    int prev;
    int guard;

    initial begin
        // Reset state
        cyc(0, 0, 0, 3, 1);
        cyc(1, 1, 1, 3, 1);
        check("rst_idx", int'(color_index), 0);
        check("rst_rgb", int'(rgb), 0);

        // Manual forward walk through the table
        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, 0, 3);
            cyc(0, 0, 0, 3);
        end
        check("walk_idx", int'(color_index), 6);
        check("walk_rgb", int'(rgb), 3'b111);

        // Reverse wrap 0 -> 6
        cyc(0, 0, 0, 3, 1);
        cyc(1, 0, 0, 3);
        cyc(1, 0, 1, 3);
        check("rev_idx", int'(color_index), 6);
        cyc(0, 0, 1, 3);
        check("rev_rgb", int'(rgb), 3'b111);

        // Duty cycle at brightness 0 and 2
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0);
            if (rgb == 3'b100) cnt++;
        end
        check("duty_b0", cnt, 2);
        cyc(0, 0, 0, 2);
        cyc(0, 0, 0, 2);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 2);
            if (rgb == 3'b100) cnt++;
        end
        check("duty_b2", cnt, 6);

        // Auto mode: run past a full wrap
        cyc(0, 0, 0, 3, 1);
        for (int i = 0; i < 36; i++) cyc(0, 1, 0, 3);
        check("auto_idx", int'(color_index), 1);

        // Step on terminal count advances once
        guard = 0;
        while (m_tick != P - 1 && guard < 10) begin
            cyc(0, 1, 0, 3);
            guard++;
        end
        check("tc_found", int'(m_tick == P - 1), 1);
        prev = int'(color_index);
        cyc(1, 1, 0, 3);
        check("tc_step", int'(color_index), (prev + 1) % 7);
        prev = int'(color_index);
        for (int i = 0; i < P - 1; i++) cyc(0, 1, 0, 3);
        check("tc_hold", int'(color_index), prev);

        // Reset while in auto at index 4
        guard = 0;
        while (color_index != 3'd4 && guard < 60) begin
            cyc(0, 1, 0, 3);
            guard++;
        end
        check("reach4", int'(color_index), 4);
        cyc(0, 1, 0, 3, 1);
        check("mid_rst_idx", int'(color_index), 0);
        check("mid_rst_rgb", int'(rgb), 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 3);
            check("off_rgb", int'(rgb), 0);
        end
        check("off_idx", int'(color_index), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 5) != 0),
                1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)),
                1'($urandom_range(0, 60) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
